mux_sel_arbiter: RTL and testbench



---
 rtl/mux_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 29 ++
 rtl/mux_sel_arbiter.sv | 109 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared states, select codes and counter width for mux_sel_arbiter
// Revision : 1.0  initial release
// ============================================================================
package mux_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

  localparam int HOLD_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Round-robin pick among 4 requesters, searching upward from last+1
// Revision : 1.0  initial release
// ============================================================================
module rr_pick4
  import mux_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] winner_o,
  output logic       any_o
);

  // Walk offsets from farthest to nearest so the nearest set bit overwrites last.
  always_comb begin
    winner_o = last_i;
    for (int k = 4; k >= 1; k--) begin
      if (req_i[last_i + 2'(k)]) begin
        winner_o = last_i + 2'(k);
      end
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Purpose  : Round-robin select generator holding the mux select per grant
// Revision : 1.0  initial release
// ============================================================================
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam logic [HOLD_CNT_W-1:0] c_hold_last = HOLD_CNT_W'(HOLD_MAX - 1);

  state_e                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [3:0]            grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic [1:0]            last_q, last_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] w_winner;
  logic       w_any;
  logic       w_rel_done;
  logic       w_rel_wd;
  logic       w_rel_to;

  rr_pick4 u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (w_winner),
    .any_o    (w_any)
  );

  assign w_rel_done = done;
  assign w_rel_wd   = ~req[sel_q];
  assign w_rel_to   = (hold_cnt_q == c_hold_last);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // sel is left untouched while idle so the downstream mux stays put.
        if (w_any) begin
          sel_d      = w_winner;
          grant_d    = 4'b0001 << w_winner;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (w_rel_done || w_rel_wd || w_rel_to) begin
          grant_d    = 4'b0000;
          busy_d     = 1'b0;
          last_d     = sel_q;
          hold_cnt_d = '0;
          timeout_d  = w_rel_to & ~w_rel_done & ~w_rel_wd;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_IN0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= SEL_IN3;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Purpose  : Directed bench with a behavioural reference model for the arbiter
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc_no = 0;

  mux_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = nobody), cycles held so far, last owner.
  int         m_owner;
  int         m_held;
  int         m_last;
  logic [1:0] m_sel;
  logic       m_to;

  always @(posedge clk) begin
    cyc_no++;
    if (reset) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 2'b00; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int off = 1; off <= 4; off++) begin
        if (m_owner < 0 && req[(m_last + off) % 4]) m_owner = (m_last + off) % 4;
      end
      if (m_owner >= 0) begin
        m_sel  = 2'(m_owner);
        m_held = 1;
      end
    end else begin
      if (done || !req[m_owner] || m_held == HOLD) begin
        m_to    = (m_held == HOLD) && !done && req[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_to = 1'b0;
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] eg;
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      n_cmp++;
      if (grant !== eg || sel !== m_sel || busy !== (m_owner >= 0) || timeout !== m_to) begin
        n_err++;
        $display("FAIL model cyc%0d: grant=%b sel=%b busy=%b to=%b, required grant=%b sel=%b busy=%b to=%b",
                 cyc_no, grant, sel, busy, timeout, eg, m_sel, (m_owner >= 0), m_to);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic t);
    n_cmp++;
    if (grant !== g || sel !== s || busy !== b || timeout !== t) begin
      n_err++;
      $display("FAIL %s: grant=%b sel=%b busy=%b to=%b, required grant=%b sel=%b busy=%b to=%b",
               nm, grant, sel, busy, timeout, g, s, b, t);
    end
  endtask

  logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] tab  [8] = '{4'b1010, 4'b0110, 4'b1001, 4'b1111,
                           4'b0001, 4'b1100, 4'b0000, 4'b0011};

  initial begin
    reset = 1'b1; req = 4'b1111; done = 1'b0;
    cyc();
    chk_en = 1'b1;
    expect_out("reset_c1", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc();
    expect_out("reset_c2", 4'b0000, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    expect_out("first_grant", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Round robin with done in the second grant cycle
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("rr_grant%0d", k), rr_g[k], 2'(k % 4), 1'b1, 1'b0);
      cyc();
      done = 1'b1;
      cyc();
      done = 1'b0;
      expect_out($sformatf("rr_gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      cyc();
    end

    // Reset back to last=3, then wrap-and-skip with req=0101
    reset = 1'b1;
    cyc();
    reset = 1'b0; req = 4'b0101;
    cyc();
    expect_out("wrap_g0", 4'b0001, 2'b00, 1'b1, 1'b0);
    done = 1'b1; cyc(); done = 1'b0;
    expect_out("wrap_idle", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc();
    expect_out("wrap_g2", 4'b0100, 2'b10, 1'b1, 1'b0);
    done = 1'b1; cyc(); done = 1'b0; cyc();
    expect_out("wrap_g0b", 4'b0001, 2'b00, 1'b1, 1'b0);
    done = 1'b1; cyc(); done = 1'b0; cyc();
    expect_out("pre_rst_g2", 4'b0100, 2'b10, 1'b1, 1'b0);

    // Mid-grant reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_out("midrst", 4'b0000, 2'b00, 1'b0, 1'b0);
    cyc();
    expect_out("post_rst_in0", 4'b0001, 2'b00, 1'b1, 1'b0);
    done = 1'b1; cyc(); done = 1'b0; req = 4'b0010;
    cyc();

    // Timeout: four grant cycles then a one-cycle pulse
    for (int k = 0; k < HOLD; k++) begin
      expect_out($sformatf("to_hold%0d", k), 4'b0010, 2'b01, 1'b1, 1'b0);
      cyc();
    end
    expect_out("to_pulse", 4'b0000, 2'b01, 1'b0, 1'b1);
    cyc();
    expect_out("to_regrant", 4'b0010, 2'b01, 1'b1, 1'b0);

    // done coinciding with the last hold cycle suppresses timeout
    cyc(HOLD - 1);
    done = 1'b1;
    cyc();
    done = 1'b0;
    expect_out("done_at_limit", 4'b0000, 2'b01, 1'b0, 1'b0);
    cyc(2);
    req = 4'b0000;
    cyc();
    expect_out("withdraw", 4'b0000, 2'b01, 1'b0, 1'b0);
    cyc();
    expect_out("idle_hold_sel", 4'b0000, 2'b01, 1'b0, 1'b0);

    // Changing requests under grant, checked by the model each cycle
    for (int i = 0; i < 48; i++) begin
      req  = tab[i % 8];
      done = (i % 5 == 3);
      cyc();
    end
    req = 4'b0000; done = 1'b0;
    cyc(3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
